buffer_ptr_ctrl: RTL

Parametrised read/write pointer controller for the router input buffer. Owns a write pointer and a read pointer over a DEPTH-entry storage array, both wrapping at DEPTH-1 to 0 (any DEPTH, not only powers of two), and tracks the occupancy count. It derives full and empty, protects against overflow and underflow, and raises sticky error flags. It sits between the input-port flow-control logic and the buffer RAM, and replaces the single fixed 3-bit pointer.

---
 rtl/buffer_pkg.sv | 22 ++
 rtl/wrap_counter.sv | 28 ++
 rtl/buffer_ptr_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared constants, width helpers and address type for the router input buffer
package buffer_pkg;

  // Default number of buffer entries.
  localparam int BUF_DEPTH = 5;

  // Pointer width for a depth; never narrower than one bit.
  function automatic int calc_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must hold the value depth itself (completely full).
  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int BUF_ADDR_W = calc_addr_w(BUF_DEPTH);

  // Slot address for the default-depth buffer RAM and its pointer controller.
  typedef logic [BUF_ADDR_W-1:0] buf_addr_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-(MAX+1) pointer that wraps from MAX back to 0
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-low clear
//   inc   - advance by one (wrapping) when high
//   value - current registered pointer value
module wrap_counter #(
  parameter int MAX   = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Explicit compare against MAX so non-power-of-two depths wrap correctly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == MAX_V) ? '0 : value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/buffer_ptr_ctrl.sv
// rtl/buffer_ptr_ctrl.sv - read/write pointer, occupancy and error-flag controller for the input buffer
// Optional feature macro: BUFFER_PTR_ALMOST_FULL_EN (adds almost_full_o).
// Ports:
//   clk           - clock, all state on rising edge
//   reset         - synchronous active-low reset
//   wr_inc_i      - write request
//   rd_inc_i      - read request
//   wr_addr_o     - slot for the write happening this cycle
//   rd_addr_o     - slot for the read happening this cycle
//   count_o       - occupancy 0..DEPTH
//   full_o        - count_o == DEPTH
//   empty_o       - count_o == 0
//   ovf_err_o     - sticky, a write was rejected
//   udf_err_o     - sticky, a read was rejected
//   almost_full_o - count_o >= AF_LEVEL (macro builds only)
module buffer_ptr_ctrl
  import buffer_pkg::*;
#(
  parameter int DEPTH    = BUF_DEPTH,
  parameter int ADDR_W   = calc_addr_w(DEPTH),
  parameter int CNT_W    = calc_cnt_w(DEPTH),
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_inc_i,
  input  logic              rd_inc_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_err_o,
`ifdef BUFFER_PTR_ALMOST_FULL_EN
  output logic              udf_err_o,
  output logic              almost_full_o
`else
  output logic              udf_err_o
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q;
  logic             rd_acc;
  logic             wr_acc;

  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

  // A read never bypasses an empty buffer; a write into a full buffer is
  // allowed only when a read frees a slot in the same cycle.
  assign rd_acc = rd_inc_i & ~empty_o;
  assign wr_acc = wr_inc_i & (~full_o | rd_acc);

  wrap_counter #(
    .MAX   (DEPTH - 1),
    .WIDTH (ADDR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_acc),
    .value (wr_addr_o)
  );

  wrap_counter #(
    .MAX   (DEPTH - 1),
    .WIDTH (ADDR_W)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc),
    .value (rd_addr_o)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q   <= '0;
      ovf_err_o <= 1'b0;
      udf_err_o <= 1'b0;
    end else begin
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (wr_inc_i && !wr_acc) begin
        ovf_err_o <= 1'b1;
      end
      if (rd_inc_i && !rd_acc) begin
        udf_err_o <= 1'b1;
      end
    end
  end

`ifdef BUFFER_PTR_ALMOST_FULL_EN
  assign almost_full_o = (count_q >= CNT_W'(AF_LEVEL));
`else
  // AF_LEVEL has no effect here; the empty block only keeps the parameter
  // referenced so both builds share one parameter list.
  if (AF_LEVEL < 0) begin : g_af_level_unused
  end
`endif

endmodule
